// File: rtl/nn_pkg.sv
// Shared definitions for the small MLP datapath: data/address widths, layer sizes and the
// 2-bit state encoding used by the ReLU sequencers.
package nn_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned L1_SIZE   = 64;
  // Wide enough to count every element of a layer-1 run (0..64).
  localparam int unsigned POS_CNT_W = 7;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

endpackage

// File: rtl/relu_elem.sv
// Combinational single-element ReLU.
//   x      : signed two's-complement input
//   y      : relu(x) = x when the sign bit is clear, else 0
//   is_pos : x is strictly positive (sign clear and nonzero)
module relu_elem #(
  parameter int unsigned DATA_W = 32
) (
  input  logic signed [DATA_W-1:0] x,
  output logic signed [DATA_W-1:0] y,
  output logic                     is_pos
);

  always_comb begin
    y      = x[DATA_W-1] ? '0 : x;
    is_pos = ~x[DATA_W-1] & (|x);
  end

endmodule

// File: rtl/relu1_unit.sv
// Layer-1 ReLU sequencer: streams NUM_ELEMS pre-activations out of the fc1 output memory,
// clamps negatives to zero and writes each result to the same address in relu1_memory.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start / busy/done : run handshake with the network controller (start/done are pulses)
//   src_read_addr     : registered read address into fc1 memory; src_data_in returns its data
//   dst_write_*       : registered write port into relu1_memory (addr, data, enable)
//   pos_count         : strictly positive inputs seen in the last run, valid from done
module relu1_unit #(
  parameter int unsigned NUM_ELEMS = nn_pkg::L1_SIZE,
  parameter int unsigned DATA_W    = nn_pkg::DATA_W,
  parameter int unsigned ADDR_W    = nn_pkg::ADDR_W
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic        [ADDR_W-1:0]        src_read_addr,
  input  logic signed [DATA_W-1:0]        src_data_in,
  output logic        [ADDR_W-1:0]        dst_write_addr,
  output logic signed [DATA_W-1:0]        dst_data_out,
  output logic                            dst_write_enable,
  output logic [nn_pkg::POS_CNT_W-1:0]    pos_count
);

  import nn_pkg::*;

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_ELEMS - 1);

  logic [1:0]               state_q, state_d;
  logic [ADDR_W-1:0]        rd_cnt_q, rd_cnt_d;
  // Set while src_read_addr_q holds an address whose data must be written next edge.
  logic                     rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0]        src_read_addr_q, src_read_addr_d;
  logic [ADDR_W-1:0]        dst_write_addr_q, dst_write_addr_d;
  logic signed [DATA_W-1:0] dst_data_q, dst_data_d;
  logic                     dst_we_q, dst_we_d;
  logic [POS_CNT_W-1:0]     pos_count_q, pos_count_d;

  logic signed [DATA_W-1:0] relu_y;
  logic                     relu_pos;

  relu_elem #(
    .DATA_W (DATA_W)
  ) u_relu_elem (
    .x      (src_data_in),
    .y      (relu_y),
    .is_pos (relu_pos)
  );

  always_comb begin
    state_d          = state_q;
    rd_cnt_d         = rd_cnt_q;
    rd_valid_d       = 1'b0;
    src_read_addr_d  = src_read_addr_q;
    dst_write_addr_d = dst_write_addr_q;
    dst_data_d       = dst_data_q;
    pos_count_d      = pos_count_q;

    unique case (state_q)
      StIdle: begin
        src_read_addr_d = '0;
        if (start) begin
          state_d     = StRun;
          rd_cnt_d    = '0;
          pos_count_d = '0;
        end
      end
      StRun: begin
        src_read_addr_d = rd_cnt_q;
        rd_valid_d      = 1'b1;
        rd_cnt_d        = rd_cnt_q + ADDR_W'(1);
        if (rd_cnt_q == LastIdx) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Stay until the last read has turned into a write strobe.
        if (!rd_valid_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        src_read_addr_d = '0;
        state_d         = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Write stage: the read data for src_read_addr_q is captured on this edge.
    dst_we_d = rd_valid_q;
    if (rd_valid_q) begin
      dst_write_addr_d = src_read_addr_q;
      dst_data_d       = relu_y;
      if (relu_pos) begin
        pos_count_d = pos_count_q + POS_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      rd_cnt_q         <= '0;
      rd_valid_q       <= 1'b0;
      src_read_addr_q  <= '0;
      dst_write_addr_q <= '0;
      dst_data_q       <= '0;
      dst_we_q         <= 1'b0;
      pos_count_q      <= '0;
    end else begin
      state_q          <= state_d;
      rd_cnt_q         <= rd_cnt_d;
      rd_valid_q       <= rd_valid_d;
      src_read_addr_q  <= src_read_addr_d;
      dst_write_addr_q <= dst_write_addr_d;
      dst_data_q       <= dst_data_d;
      dst_we_q         <= dst_we_d;
      pos_count_q      <= pos_count_d;
    end
  end

  assign busy             = (state_q == StRun) || (state_q == StDrain);
  assign done             = (state_q == StDone);
  assign src_read_addr    = src_read_addr_q;
  assign dst_write_addr   = dst_write_addr_q;
  assign dst_data_out     = dst_data_q;
  assign dst_write_enable = dst_we_q;
  assign pos_count        = pos_count_q;

endmodule

// File: tb/tb_relu1_unit.sv
// Scoreboard bench for relu1_unit: each run pushes the expected (addr, data) writes into a
// queue; an independent monitor pops and compares on every write strobe.
module tb_relu1_unit;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               busy;
  logic               done;
  logic [15:0]        src_read_addr;
  logic signed [31:0] src_data_in;
  logic [15:0]        dst_write_addr;
  logic signed [31:0] dst_data_out;
  logic               dst_write_enable;
  logic [6:0]         pos_count;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t               exp_q[$];
  logic signed [31:0] src_mem [64];
  int                 checks = 0;
  int                 failures = 0;
  int                 write_cnt = 0;
  int                 done_pulses = 0;

  always #5 clk = ~clk;

  assign src_data_in = (src_read_addr < 16'd64) ? src_mem[src_read_addr[5:0]] : 32'sd0;

  relu1_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .src_read_addr    (src_read_addr),
    .src_data_in      (src_data_in),
    .dst_write_addr   (dst_write_addr),
    .dst_data_out     (dst_data_out),
    .dst_write_enable (dst_write_enable),
    .pos_count        (pos_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compares every write strobe against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_pulses++;
      if (dst_write_enable) begin
        exp_t e;
        write_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual_addr=%0d required=none", dst_write_addr);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(dst_write_addr), 32'(e.addr));
          check("wr_data", dst_data_out, e.data);
        end
      end
    end
  end

  task automatic push_expected();
    for (int i = 0; i < 64; i++) begin
      exp_t e;
      e.addr = 16'(i);
      e.data = (src_mem[i] > 0) ? src_mem[i] : 32'sd0;
      exp_q.push_back(e);
    end
  endtask

  task automatic load_ramp();
    for (int i = 0; i < 64; i++) src_mem[i] = 32'(i - 32);
  endtask

  // One full run; start is raised on the negedge after entry (i.e. the cycle after any
  // preceding done). inject_at>0 re-pulses start mid-run; start_on_done pulses it in DONE.
  task automatic do_run(input string tag, input int inject_at, input int exp_pos,
                        input bit start_on_done);
    int n;
    int first_we;
    int wc0;
    int dp0;
    push_expected();
    @(negedge clk);
    start = 1'b1;
    wc0 = write_cnt;
    dp0 = done_pulses;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    n = 0;
    first_we = -1;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      start = (n == inject_at);
      if (dst_write_enable && first_we < 0) first_we = n;
    end
    start = 1'b0;
    #1;
    check({tag, "_done_latency"}, 32'(n), 32'd66);
    check({tag, "_first_write"}, 32'(first_we), 32'd2);
    check({tag, "_pos_count"}, 32'(pos_count), 32'(exp_pos));
    check({tag, "_write_count"}, 32'(write_cnt - wc0), 32'd64);
    check({tag, "_done_pulses"}, 32'(done_pulses - dp0), 32'd1);
    check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    if (start_on_done) start = 1'b1;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 64; i++) src_mem[i] = '0;

    // 1: reset, with start held during reset
    rst_n = 1'b0;
    start = 1'b1;
    #13;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_we", 32'(dst_write_enable), 32'd0);
    check("rst_src_addr", 32'(src_read_addr), 32'd0);
    check("rst_dst_addr", 32'(dst_write_addr), 32'd0);
    check("rst_dst_data", dst_data_out, 32'd0);
    check("rst_pos_count", 32'(pos_count), 32'd0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_reset", 32'(busy), 32'd0);

    // 2: ramp i-32
    load_ramp();
    do_run("ramp", 0, 31, 1'b0);

    // 3: extremes
    for (int i = 0; i < 64; i++) src_mem[i] = -32'sd5;
    src_mem[0] = 32'h8000_0000;
    src_mem[1] = 32'h7FFF_FFFF;
    src_mem[2] = 32'h0000_0000;
    src_mem[3] = 32'hFFFF_FFFF;
    do_run("extreme", 0, 1, 1'b0);

    // 4: start pulse mid-run is ignored
    load_ramp();
    do_run("busy_start", 10, 31, 1'b0);

    // 5: reset during the write of address 20
    load_ramp();
    push_expected();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(dst_write_enable && dst_write_addr == 16'd20) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("midrst_reached_addr20", 32'(n), 32'd22);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_we", 32'(dst_write_enable), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_src_addr", 32'(src_read_addr), 32'd0);
    check("midrst_dst_addr", 32'(dst_write_addr), 32'd0);
    exp_q.delete();
    n = done_pulses;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_no_done", 32'(done_pulses - n), 32'd0);
    // Restart must rewrite from address 0; start is also raised in DONE (must be ignored).
    do_run("restart", 0, 31, 1'b1);

    // 6: back-to-back with a fresh data set (multiples of 3 positive, 0 at index 0)
    for (int i = 0; i < 64; i++) src_mem[i] = (i % 3 == 0) ? 32'(i * 1000) : 32'(-i * 7);
    do_run("b2b", 0, 21, 1'b0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
